cmd_host_arbiter: RTL and testbench

- Shares the single host port of cmd_master between NUM_REQ independent requesters, e.g. a UART debug bridge, an embedded CPU and a config-ROM loader.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Presents the identical sel/rd_wr_n/byte_addr/wdata/ack/rdata handshake on both sides, so requesters connect as if wired straight to cmd_master.

---
 rtl/cmd_host_arbiter_if.sv | 33 +++
 rtl/cmd_host_arbiter.sv | 93 +++++++++
 tb/tb_cmd_host_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_host_arbiter_if.sv
// cmd_host_arbiter_if: requester-side and host-side handshake bundle of cmd_host_arbiter.
interface cmd_host_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]           i_req_sel;
  logic [NUM_REQ-1:0]           i_req_rd_wr_n;
  logic [NUM_REQ*ADDR_BITS-1:0] i_req_byte_addr;
  logic [NUM_REQ*DATA_BITS-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]           o_req_ack;
  logic [NUM_REQ-1:0]           o_req_err;
  logic [DATA_BITS-1:0]         o_req_rdata;
  logic                         o_host_sel;
  logic                         o_host_rd_wr_n;
  logic [ADDR_BITS-1:0]         o_host_byte_addr;
  logic [DATA_BITS-1:0]         o_host_wdata;
  logic                         i_host_ack;
  logic [DATA_BITS-1:0]         i_host_rdata;
  logic [GW-1:0]                o_grant;
  logic                         o_busy;
  modport slave (
    input  i_req_sel, i_req_rd_wr_n, i_req_byte_addr, i_req_wdata, i_host_ack, i_host_rdata,
    output o_req_ack, o_req_err, o_req_rdata, o_host_sel, o_host_rd_wr_n, o_host_byte_addr,
           o_host_wdata, o_grant, o_busy
  );
  modport master (
    output i_req_sel, i_req_rd_wr_n, i_req_byte_addr, i_req_wdata, i_host_ack, i_host_rdata,
    input  o_req_ack, o_req_err, o_req_rdata, o_host_sel, o_host_rd_wr_n, o_host_byte_addr,
           o_host_wdata, o_grant, o_busy
  );
endinterface

// File: rtl/cmd_host_arbiter.sv
// cmd_host_arbiter: round-robin sharing of one cmd_master host port among NUM_REQ requesters.
// Define CMD_ARB_TIMEOUT_EN to add a WAIT-state watchdog that completes stalled transactions with an error.
module cmd_host_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          ADDR_BITS      = 32,
  parameter int          DATA_BITS      = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input logic               i_sysclk,
  input logic               i_srst,
  cmd_host_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [DATA_BITS-1:0] TMO_DATA = DATA_BITS'(TIMEOUT_RDATA);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;
  state_t state, state_nx;
  logic [GW-1:0] ptr, pick;
  logic found, tmo, done;
  int j;
  always_comb begin
    pick = '0;
    found = 1'b0;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (bus.i_req_sel[j]) begin
        pick = GW'(j);
        found = 1'b1;
      end
    end
  end
  assign done = state == WAIT && (bus.i_host_ack || tmo);
  always_ff @(posedge i_sysclk or posedge i_srst)
    if (i_srst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? WAIT : IDLE;
      WAIT:    state_nx = done ? ACK : WAIT;
      ACK:     state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      ptr                  <= '0;
      bus.o_host_sel       <= 1'b0;
      bus.o_host_rd_wr_n   <= 1'b0;
      bus.o_host_byte_addr <= '0;
      bus.o_host_wdata     <= '0;
      bus.o_req_ack        <= '0;
      bus.o_req_rdata      <= '0;
      bus.o_grant          <= '0;
      bus.o_busy           <= 1'b0;
    end else begin
      bus.o_req_ack <= '0;
      bus.o_busy    <= state_nx != IDLE;
      if (state == IDLE && found) begin
        bus.o_host_sel       <= 1'b1;
        bus.o_host_rd_wr_n   <= bus.i_req_rd_wr_n[pick];
        bus.o_host_byte_addr <= bus.i_req_byte_addr[pick*ADDR_BITS +: ADDR_BITS];
        bus.o_host_wdata     <= bus.i_req_wdata[pick*DATA_BITS +: DATA_BITS];
        bus.o_grant          <= pick;
      end
      if (done) begin
        bus.o_host_sel  <= 1'b0;
        bus.o_req_rdata <= tmo ? TMO_DATA : bus.i_host_rdata;
        bus.o_req_ack   <= NUM_REQ'(1) << bus.o_grant;
        ptr             <= (bus.o_grant == GW'(NUM_REQ - 1)) ? '0 : bus.o_grant + 1'b1;
      end
    end
  end
`ifdef CMD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // a host ack in the limit cycle wins, so it masks the timeout
  assign tmo = state == WAIT && !bus.i_host_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      cnt           <= '0;
      bus.o_req_err <= '0;
    end else begin
      cnt           <= (state == WAIT) ? cnt + 1'b1 : '0;
      bus.o_req_err <= tmo ? NUM_REQ'(1) << bus.o_grant : '0;
    end
  end
`else
  assign tmo = 1'b0;
  assign bus.o_req_err = '0;
`endif
endmodule

// File: tb/tb_cmd_host_arbiter.sv
// tb_cmd_host_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_cmd_host_arbiter;
  localparam int N  = 4;
  localparam int TC = 16;
`ifdef CMD_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ack_log[$];
  cmd_host_arbiter_if #(.NUM_REQ(N), .ADDR_BITS(32), .DATA_BITS(32)) bus ();
  cmd_host_arbiter #(.NUM_REQ(N), .ADDR_BITS(32), .DATA_BITS(32), .TIMEOUT_CYCLES(TC)) dut (
    .i_sysclk(clk), .i_srst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a transaction is either in flight, cooling down after its ack, or absent
  bit          m_active, m_sel, m_rw;
  int          m_cool, m_ptr, m_grant, m_wcnt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_ack, m_err;
  function automatic int pick(input int p, input logic [3:0] s);
    for (int k = 0; k < N; k++) if (s[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_sel <= 0; m_rw <= 0; m_cool <= 0; m_ptr <= 0; m_grant <= 0; m_wcnt <= 0;
      m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_ack <= 0; m_err <= 0;
    end else begin
      m_ack <= 0;
      m_err <= 0;
      if (m_active) begin
        m_wcnt <= m_wcnt + 1;
        if (bus.i_host_ack || (TMO_ON && m_wcnt == TC - 1)) begin
          m_active <= 0;
          m_sel    <= 0;
          m_cool   <= 2;
          m_ack    <= 4'(1) << m_grant;
          m_err    <= bus.i_host_ack ? 4'(0) : 4'(1) << m_grant;
          m_rdata  <= bus.i_host_ack ? bus.i_host_rdata : 32'hDEAD_BEEF;
          m_ptr    <= (m_grant + 1) % N;
        end
      end else if (m_cool > 0) m_cool <= m_cool - 1;
      else if (pick(m_ptr, bus.i_req_sel) >= 0) begin
        m_active <= 1;
        m_sel    <= 1;
        m_wcnt   <= 0;
        m_grant  <= pick(m_ptr, bus.i_req_sel);
        m_rw     <= bus.i_req_rd_wr_n[pick(m_ptr, bus.i_req_sel)];
        m_addr   <= bus.i_req_byte_addr[pick(m_ptr, bus.i_req_sel)*32 +: 32];
        m_wdata  <= bus.i_req_wdata[pick(m_ptr, bus.i_req_sel)*32 +: 32];
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    check("sel", bus.o_host_sel, m_sel);
    check("ack", bus.o_req_ack, m_ack);
    check("err", bus.o_req_err, m_err);
    check("busy", bus.o_busy, m_active || m_cool > 0);
    check("grant", bus.o_grant, m_grant);
    check("rdata", bus.o_req_rdata, m_rdata);
    if (m_sel) begin
      check("rw", bus.o_host_rd_wr_n, m_rw);
      check("addr", bus.o_host_byte_addr, m_addr);
      check("wdata", bus.o_host_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int r, input bit s, input bit rw, input logic [31:0] a, input logic [31:0] d);
    bus.i_req_sel[r] = s;
    bus.i_req_rd_wr_n[r] = rw;
    bus.i_req_byte_addr[r*32 +: 32] = a;
    bus.i_req_wdata[r*32 +: 32] = d;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_sel = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_sel();
    int n = 0;
    while (!bus.o_host_sel && n < 50) begin
      tick();
      n++;
    end
    if (!bus.o_host_sel) check("wait_sel_bound", 0, 1);
  endtask
  task automatic pulse_ack(input int dly, input logic [31:0] d);
    repeat (dly - 1) tick();
    bus.i_host_ack = 1'b1;
    bus.i_host_rdata = d;
    tick();
    bus.i_host_ack = 1'b0;
  endtask
  function automatic int idx(input logic [3:0] oh);
    for (int k = 0; k < N; k++) if (oh[k]) return k;
    return -1;
  endfunction

  initial begin
    bus.i_req_sel = '0;
    bus.i_req_rd_wr_n = '0;
    bus.i_req_byte_addr = '0;
    bus.i_req_wdata = '0;
    bus.i_host_ack = 1'b0;
    bus.i_host_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_sel", bus.o_host_sel, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_ack", bus.o_req_ack, 0);
    check("rst_grant", bus.o_grant, 0);
    check("rst_rdata", bus.o_req_rdata, 0);
    // single read from requester 1
    set_req(1, 1, 1, 32'h10, 32'h0);
    wait_sel();
    check("rd_addr", bus.o_host_byte_addr, 32'h10);
    check("rd_rw", bus.o_host_rd_wr_n, 1);
    check("rd_grant", bus.o_grant, 1);
    pulse_ack(4, 32'h1234_5678);
    bus.i_req_sel[1] = 1'b0;
    check("rd_ack", bus.o_req_ack, 4'b0010);
    check("rd_rdata", bus.o_req_rdata, 32'h1234_5678);
    repeat (3) tick();
    // round robin with all four requesting
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 1, 1, 32'h100 * r, 32'h0);
    for (int t = 0; t < 6; t++) begin
      wait_sel();
      pulse_ack(2, 32'h1000 + t);
      ack_log.push_back(idx(bus.o_req_ack));
    end
    bus.i_req_sel = '0;
    for (int t = 0; t < 6; t++) check("rr_order", ack_log[t], t % N);
    repeat (3) tick();
    // pointer wrap: serve req2 so the pointer sits at 3, then req0 and req2 compete
    do_reset();
    set_req(2, 1, 1, 32'h200, 32'h0);
    wait_sel();
    pulse_ack(1, 32'h0);
    bus.i_req_sel[2] = 1'b0;
    set_req(0, 1, 0, 32'h40, 32'h5555_0000);
    set_req(2, 1, 1, 32'h240, 32'h0);
    wait_sel();
    check("wrap_first", bus.o_grant, 0);
    pulse_ack(1, 32'hAAAA_0000);
    bus.i_req_sel[0] = 1'b0;
    wait_sel();
    check("wrap_second", bus.o_grant, 2);
    pulse_ack(1, 32'hBBBB_0000);
    bus.i_req_sel[2] = 1'b0;
    repeat (3) tick();
    // write stability while the requester changes its inputs
    set_req(2, 1, 0, 32'h20, 32'hCAFE_F00D);
    wait_sel();
    set_req(2, 1, 1, 32'h999, 32'h1111_2222);
    repeat (3) tick();
    check("wr_addr", bus.o_host_byte_addr, 32'h20);
    check("wr_data", bus.o_host_wdata, 32'hCAFE_F00D);
    check("wr_rw", bus.o_host_rd_wr_n, 0);
    pulse_ack(1, 32'h0);
    bus.i_req_sel[2] = 1'b0;
    repeat (3) tick();
    // asynchronous reset in the middle of WAIT
    set_req(1, 1, 1, 32'h30, 32'h0);
    wait_sel();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sel", bus.o_host_sel, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_ack", bus.o_req_ack, 0);
    tick();
    set_req(0, 1, 1, 32'h50, 32'h0);
    tick();
    rst = 1'b0;
    wait_sel();
    check("post_rst_grant", bus.o_grant, 0);
    pulse_ack(2, 32'h7777_0000);
    bus.i_req_sel[0] = 1'b0;
    wait_sel();
    check("post_rst_next", bus.o_grant, 1);
    pulse_ack(2, 32'h8888_0000);
    bus.i_req_sel[1] = 1'b0;
    repeat (3) tick();
`ifdef CMD_ARB_TIMEOUT_EN
    begin
      int n = 0;
      set_req(3, 1, 1, 32'h60, 32'h0);
      wait_sel();
      while (bus.o_req_ack == 0 && n < 40) begin
        tick();
        n++;
      end
      bus.i_req_sel[3] = 1'b0;
      check("tmo_cycles", n, TC);
      check("tmo_ack", bus.o_req_ack, 4'b1000);
      check("tmo_err", bus.o_req_err, 4'b1000);
      check("tmo_rdata", bus.o_req_rdata, 32'hDEAD_BEEF);
    end
`endif
    // stray host ack with nothing in flight
    bus.i_host_ack = 1'b1;
    bus.i_host_rdata = 32'h0BAD_0BAD;
    tick();
    bus.i_host_ack = 1'b0;
    repeat (3) tick();
    check("stray_busy", bus.o_busy, 0);
    check("stray_ack", bus.o_req_ack, 0);
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
